// File: rtl/xadc_pkg.sv
// Shared XADC definitions: FSM state encoding, DRP/ADC widths and default constants.
package xadc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } xadc_state_e;

   localparam int DRP_AW = 7;
   localparam int DRP_DW = 16;
   localparam int ADC_W  = 12;

   localparam logic [DRP_AW-1:0] XADC_BASE_ADDR = 7'h10;
   localparam int                XADC_TIMEOUT   = 63;

endpackage

// File: rtl/xadc_result_bank.sv
// Per-channel result store: one write port, one registered read port, cleared on reset.
module xadc_result_bank
   import xadc_pkg::*;
#(
   parameter int CH_BITS = 3
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_we,
   input  logic [CH_BITS-1:0] i_waddr,
   input  logic [ADC_W-1:0]   i_wdata,
   input  logic [CH_BITS-1:0] i_raddr,
   output logic [ADC_W-1:0]   o_rdata
);

   localparam int DEPTH = 2 ** CH_BITS;

   logic [ADC_W-1:0] r_mem [DEPTH];
   logic [ADC_W-1:0] r_rdata;

   // Storage and read register; a same-entry read/write returns the old value.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_rdata <= '0;
      end else begin
         r_rdata <= r_mem[i_raddr];
         if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
         end
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/xadc_drp_scanner.sv
// Reads the XADC result of the channel named by the channel counter on every
// end-of-conversion, stores it in a per-channel bank and pulses o_sample_valid.
//
// DRP handshake: o_drp_den is a single-cycle request carrying o_drp_daddr; the
// XADC answers with a single-cycle i_drp_drdy carrying i_drp_do. Only one read is
// outstanding; drdy is honoured only while waiting for it.
module xadc_drp_scanner
   import xadc_pkg::*;
#(
   parameter logic [DRP_AW-1:0] BASE_ADDR = XADC_BASE_ADDR,
   parameter int                CH_BITS   = 3,
   parameter int                TIMEOUT   = XADC_TIMEOUT
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [CH_BITS-1:0] i_chan_sel,
   input  logic               i_eoc,
   output logic [DRP_AW-1:0]  o_drp_daddr,
   output logic               o_drp_den,
   output logic               o_drp_dwe,
   input  logic [DRP_DW-1:0]  i_drp_do,
   input  logic               i_drp_drdy,
   output logic [ADC_W-1:0]   o_sample,
   output logic [CH_BITS-1:0] o_sample_chan,
   output logic               o_sample_valid,
   output logic               o_busy,
   output logic               o_overrun,
   output logic               o_timeout_err,
   input  logic [CH_BITS-1:0] i_rd_addr,
   output logic [ADC_W-1:0]   o_rd_data,
   output xadc_state_e        o_dbg_state
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   xadc_state_e        r_state;
   logic [CH_BITS-1:0] r_ch;
   logic [DRP_AW-1:0]  r_daddr;
   logic               r_den;
   logic [CNT_W-1:0]   r_cnt;
   logic [ADC_W-1:0]   r_sample;
   logic [CH_BITS-1:0] r_sample_chan;
   logic               r_valid;
   logic               r_overrun;
   logic               r_tout;

   logic               w_bank_we;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               w_cnt_hit;

   // The bank is written on the same edge that captures o_sample.
   assign w_bank_we = (r_state == ST_WAIT) && i_drp_drdy;
   assign w_cnt_nxt = r_cnt + 1'b1;
   assign w_cnt_hit = (w_cnt_nxt == CNT_W'(TIMEOUT));

   // Read sequencer: request, wait for drdy or timeout, then publish the sample.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= ST_IDLE;
         r_ch          <= '0;
         r_daddr       <= BASE_ADDR;
         r_den         <= 1'b0;
         r_cnt         <= '0;
         r_sample      <= '0;
         r_sample_chan <= '0;
         r_valid       <= 1'b0;
         r_overrun     <= 1'b0;
         r_tout        <= 1'b0;
      end else begin
         r_den   <= 1'b0;
         r_valid <= 1'b0;
         r_tout  <= 1'b0;
         if (i_eoc && (r_state != ST_IDLE)) begin
            r_overrun <= 1'b1;
         end
         case (r_state)
            ST_IDLE: begin
               if (i_eoc) begin
                  r_ch    <= i_chan_sel;
                  r_daddr <= BASE_ADDR + DRP_AW'(i_chan_sel);
                  r_den   <= 1'b1;
                  r_state <= ST_REQ;
               end
            end
            ST_REQ: begin
               r_cnt   <= '0;
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (i_drp_drdy) begin
                  r_sample      <= i_drp_do[DRP_DW-1 -: ADC_W];
                  r_sample_chan <= r_ch;
                  r_valid       <= 1'b1;
                  r_state       <= ST_DONE;
               end else if (w_cnt_hit) begin
                  r_tout  <= 1'b1;
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= w_cnt_nxt;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   xadc_result_bank #(
      .CH_BITS (CH_BITS)
   ) u_bank (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_we    (w_bank_we),
      .i_waddr (r_ch),
      .i_wdata (i_drp_do[DRP_DW-1 -: ADC_W]),
      .i_raddr (i_rd_addr),
      .o_rdata (o_rd_data)
   );

   assign o_drp_daddr    = r_daddr;
   assign o_drp_den      = r_den;
   assign o_drp_dwe      = 1'b0;
   assign o_sample       = r_sample;
   assign o_sample_chan  = r_sample_chan;
   assign o_sample_valid = r_valid;
   assign o_busy         = (r_state != ST_IDLE);
   assign o_overrun      = r_overrun;
   assign o_timeout_err  = r_tout;
   assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_xadc_drp_scanner.sv
// Directed bench for xadc_drp_scanner: single read, channel sweep, overrun,
// timeout, mid-read reset and drdy on the timeout cycle.
module tb_xadc_drp_scanner;
   import xadc_pkg::*;

   logic              i_clk;
   logic              i_rst;
   logic [2:0]        i_chan_sel;
   logic              i_eoc;
   logic [6:0]        o_drp_daddr;
   logic              o_drp_den;
   logic              o_drp_dwe;
   logic [15:0]       i_drp_do;
   logic              i_drp_drdy;
   logic [11:0]       o_sample;
   logic [2:0]        o_sample_chan;
   logic              o_sample_valid;
   logic              o_busy;
   logic              o_overrun;
   logic              o_timeout_err;
   logic [2:0]        i_rd_addr;
   logic [11:0]       o_rd_data;
   xadc_state_e       o_dbg_state;

   int n_tests = 0;
   int n_fail  = 0;
   int den_cnt = 0;
   int val_cnt = 0;
   int tout_cnt = 0;

   xadc_drp_scanner dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_chan_sel     (i_chan_sel),
      .i_eoc          (i_eoc),
      .o_drp_daddr    (o_drp_daddr),
      .o_drp_den      (o_drp_den),
      .o_drp_dwe      (o_drp_dwe),
      .i_drp_do       (i_drp_do),
      .i_drp_drdy     (i_drp_drdy),
      .o_sample       (o_sample),
      .o_sample_chan  (o_sample_chan),
      .o_sample_valid (o_sample_valid),
      .o_busy         (o_busy),
      .o_overrun      (o_overrun),
      .o_timeout_err  (o_timeout_err),
      .i_rd_addr      (i_rd_addr),
      .o_rd_data      (o_rd_data),
      .o_dbg_state    (o_dbg_state)
   );

   // Clock
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // Pulse counters sampled away from the active edge
   always @(negedge i_clk) begin
      if (o_drp_den)      den_cnt++;
      if (o_sample_valid) val_cnt++;
      if (o_timeout_err)  tout_cnt++;
   end

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference value the DRP model returns for a given address
   function automatic logic [11:0] model_val(input logic [6:0] addr);
      return 12'h5A0 ^ {5'b0, addr};
   endfunction

   // eoc on ch, drdy dly cycles after den carrying d; checks request and result
   task automatic read_txn(input logic [2:0] ch, input int dly, input logic [15:0] d);
      logic [6:0] ea;
      ea = 7'h10 + {4'b0, ch};
      i_chan_sel = ch;
      i_eoc = 1'b1;
      step();
      i_eoc = 1'b0;
      chk("den", o_drp_den, 1);
      chk("daddr", o_drp_daddr, ea);
      chk("dwe", o_drp_dwe, 0);
      repeat (dly) step();
      i_drp_drdy = 1'b1;
      i_drp_do = d;
      step();
      i_drp_drdy = 1'b0;
      i_drp_do = 16'h0;
      chk("valid", o_sample_valid, 1);
      chk("sample", o_sample, d[15:4]);
      chk("sample_chan", o_sample_chan, ch);
      step();
      chk("valid_low", o_sample_valid, 0);
      chk("busy_low", o_busy, 0);
   endtask

   task automatic bank_chk(input logic [2:0] a, input logic [11:0] exp);
      i_rd_addr = a;
      step();
      chk($sformatf("bank[%0d]", a), o_rd_data, exp);
   endtask

   int d0, v0, t0;

   initial begin
      i_rst = 1'b1; i_chan_sel = '0; i_eoc = 1'b0;
      i_drp_do = '0; i_drp_drdy = 1'b0; i_rd_addr = '0;
      repeat (3) step();
      i_rst = 1'b0;

      // Reset state
      chk("rst_daddr", o_drp_daddr, 7'h10);
      chk("rst_den", o_drp_den, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_valid", o_sample_valid, 0);
      chk("rst_sample", o_sample, 0);
      chk("rst_overrun", o_overrun, 0);
      chk("rst_state", o_dbg_state, ST_IDLE);
      chk("rst_rd_data", o_rd_data, 0);

      // 1: single read of channel 3
      d0 = den_cnt;
      read_txn(3'd3, 4, 16'hABC0);
      chk("t1_den_count", den_cnt - d0, 1);
      bank_chk(3'd3, 12'hABC);

      // 2: sweep all channels, then wrap to channel 0
      for (int n = 0; n < 8; n++) begin
         logic [6:0] a;
         a = 7'h10 + 7'(n);
         read_txn(3'(n), 1 + (n % 3), {model_val(a), 4'hF});
      end
      for (int n = 0; n < 8; n++) begin
         bank_chk(3'(n), model_val(7'h10 + 7'(n)));
      end
      read_txn(3'd0, 2, 16'h1234);
      bank_chk(3'd0, 12'h123);
      bank_chk(3'd1, model_val(7'h11));

      // 3: second eoc while waiting sets overrun, no extra read
      d0 = den_cnt; v0 = val_cnt;
      i_chan_sel = 3'd2; i_eoc = 1'b1; step();
      i_eoc = 1'b0; step();
      i_chan_sel = 3'd5; i_eoc = 1'b1; step();
      i_eoc = 1'b0;
      chk("t3_overrun", o_overrun, 1);
      i_drp_drdy = 1'b1; i_drp_do = 16'h7770; step();
      i_drp_drdy = 1'b0;
      chk("t3_chan", o_sample_chan, 2);
      repeat (4) step();
      chk("t3_den_count", den_cnt - d0, 1);
      chk("t3_val_count", val_cnt - v0, 1);
      chk("t3_overrun_sticky", o_overrun, 1);

      // 4: no drdy -> timeout pulse TIMEOUT+1 cycles after den
      v0 = val_cnt; t0 = tout_cnt;
      i_chan_sel = 3'd6; i_eoc = 1'b1; step();
      i_eoc = 1'b0;
      chk("t4_den", o_drp_den, 1);
      repeat (63) step();
      chk("t4_tout_early", o_timeout_err, 0);
      chk("t4_busy", o_busy, 1);
      step();
      chk("t4_tout", o_timeout_err, 1);
      chk("t4_idle", o_busy, 0);
      step();
      chk("t4_tout_pulse", o_timeout_err, 0);
      chk("t4_no_valid", val_cnt - v0, 0);
      bank_chk(3'd6, model_val(7'h16));
      read_txn(3'd6, 3, 16'h4560);
      bank_chk(3'd6, 12'h456);

      // 5: reset while waiting, drdy arrives afterwards
      v0 = val_cnt;
      i_chan_sel = 3'd4; i_eoc = 1'b1; step();
      i_eoc = 1'b0; step();
      i_rst = 1'b1; step();
      i_rst = 1'b0;
      i_drp_drdy = 1'b1; i_drp_do = 16'hFFF0; step();
      i_drp_drdy = 1'b0;
      chk("t5_den", o_drp_den, 0);
      chk("t5_busy", o_busy, 0);
      chk("t5_overrun", o_overrun, 0);
      step();
      chk("t5_no_valid", val_cnt - v0, 0);
      for (int n = 0; n < 8; n++) begin
         bank_chk(3'(n), 12'h000);
      end

      // 6: drdy on the timeout decision cycle wins
      v0 = val_cnt; t0 = tout_cnt;
      i_chan_sel = 3'd7; i_eoc = 1'b1; step();
      i_eoc = 1'b0;
      repeat (63) step();
      i_drp_drdy = 1'b1; i_drp_do = 16'h9870; step();
      i_drp_drdy = 1'b0;
      chk("t6_valid", o_sample_valid, 1);
      chk("t6_sample", o_sample, 12'h987);
      chk("t6_no_tout", o_timeout_err, 0);
      repeat (3) step();
      chk("t6_tout_count", tout_cnt - t0, 0);
      chk("t6_val_count", val_cnt - v0, 1);
      bank_chk(3'd7, 12'h987);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
